// File: rtl/cache_bus_agent_pkg.sv
// Shared types for the per-core MESI bus agent: line states, request kinds,
// agent FSM states and the word types used on the bus.
package cc_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] longWord_t;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        E = 2'd2,
        M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        CC_READ    = 2'd0,
        CC_READX   = 2'd1,
        CC_UPGRADE = 2'd2,
        CC_WB      = 2'd3
    } cc_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } agent_state_t;

    // Line address with the byte-within-beat bits cleared.
    function automatic word_t line_base(input word_t a);
        return a & ~32'h0000_0007;
    endfunction

    // True when two addresses fall in the same line.
    function automatic logic same_line(input word_t a, input word_t b);
        return ((a ^ b) & ~32'h0000_0007) == 32'h0;
    endfunction

endpackage

// File: rtl/cache_bus_agent_if.sv
// Bus-side signals of one CPU's slice of the coherence bus controller.
// Handshake: a request strobe (dREN/dWEN/cctrans) is held while dwait is
// high; each cycle with dwait low transfers one 64-bit beat. ccwait high marks
// a snoop episode driven by the controller; snoop responses are sampled by the
// controller in the same cycle they are presented.
interface cache_bus_agent_if;

    logic             dREN;
    logic             dWEN;
    logic             ccwrite;
    logic             cctrans;
    cc_pkg::word_t     daddr;
    cc_pkg::longWord_t dstore;
    logic             ccsnoophit;
    logic             ccdirty;
    logic             ccIsPresent;
    logic             dwait;
    logic             ccwait;
    logic             ccinv;
    logic             ccexclusive;
    cc_pkg::longWord_t dload;
    cc_pkg::word_t     ccsnoopaddr;

    // Agent side.
    modport master (
        output dREN, dWEN, ccwrite, cctrans, daddr, dstore,
        output ccsnoophit, ccdirty, ccIsPresent,
        input  dwait, ccwait, ccinv, ccexclusive, dload, ccsnoopaddr
    );

    // Bus controller side.
    modport slave (
        input  dREN, dWEN, ccwrite, cctrans, daddr, dstore,
        input  ccsnoophit, ccdirty, ccIsPresent,
        output dwait, ccwait, ccinv, ccexclusive, dload, ccsnoopaddr
    );

endinterface

// File: rtl/cache_bus_agent_snoop_resp.sv
// Snoop responder: answers hit/present combinationally, registers dirty and
// supply data from the hit, and tells the L1 how to downgrade the line once
// the snoop episode ends.
module cc_snoop_resp
    import cc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      ccwait,
    input  logic      ccinv,
    input  word_t     ccsnoopaddr,
    input  mesi_t     snp_state,
    input  longWord_t snp_data,
    output word_t     snp_addr,
    output logic      snp_inv,
    output logic      snp_to_shared,
    output logic      snoop_hit,
    output logic      snoop_dirty,
    output longWord_t supply_data
);

    logic      ccwait_q,   ccwait_d;
    logic      hit_seen_q, hit_seen_d;
    logic      inv_seen_q, inv_seen_d;
    logic      dirty_q,    dirty_d;
    longWord_t supply_q,   supply_d;
    word_t     addr_q,     addr_d;
    logic      end_pulse;

    // Snoop bookkeeping: remember hit/inv per episode, capture dirty on the first hit.
    always_comb begin
        snoop_hit  = ccwait && (snp_state != I);
        ccwait_d   = ccwait;
        hit_seen_d = ccwait ? (hit_seen_q | snoop_hit) : 1'b0;
        inv_seen_d = ccwait ? (inv_seen_q | ccinv) : 1'b0;
        dirty_d    = dirty_q;
        if (!ccwait) begin
            dirty_d = 1'b0;
        end else if (snoop_hit && !hit_seen_q) begin
            dirty_d = (snp_state == M);
        end
        supply_d = snoop_hit ? snp_data : supply_q;
        addr_d   = ccwait ? ccsnoopaddr : addr_q;
        // Keep pointing the L1 at the snooped line for the end-of-episode pulse.
        snp_addr      = ccwait ? ccsnoopaddr : addr_q;
        end_pulse     = ccwait_q && !ccwait && hit_seen_q;
        snp_inv       = end_pulse && inv_seen_q;
        snp_to_shared = end_pulse && !inv_seen_q;
        snoop_dirty   = dirty_q;
        supply_data   = supply_q;
    end

    // Snoop state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccwait_q   <= 1'b0;
            hit_seen_q <= 1'b0;
            inv_seen_q <= 1'b0;
            dirty_q    <= 1'b0;
            supply_q   <= '0;
            addr_q     <= '0;
        end else begin
            ccwait_q   <= ccwait_d;
            hit_seen_q <= hit_seen_d;
            inv_seen_q <= inv_seen_d;
            dirty_q    <= dirty_d;
            supply_q   <= supply_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: rtl/cache_bus_agent.sv
// Per-core L1-side endpoint of the MESI bus: issues misses, upgrades and
// writebacks, reports the resulting line state, and answers snoops in parallel.
module cache_bus_agent
    import cc_pkg::*;
#(
    parameter int DOUBLE_BLOCK_SIZE = 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           req_valid,
    input  cc_req_t                        req_type,
    input  word_t                          req_addr,
    input  logic [64*DOUBLE_BLOCK_SIZE-1:0] req_wdata,
    output logic                           req_done,
    output logic [64*DOUBLE_BLOCK_SIZE-1:0] resp_line,
    output mesi_t                          resp_state,
    output word_t                          snp_addr,
    input  mesi_t                          snp_state,
    input  longWord_t                      snp_data,
    output logic                           snp_inv,
    output logic                           snp_to_shared,
    output agent_state_t                   dbg_state,
    cache_bus_agent_if.master              bus
);

    localparam int LINE_W = 64 * DOUBLE_BLOCK_SIZE;
    localparam int BEAT_CNT_W = (DOUBLE_BLOCK_SIZE > 1) ? $clog2(DOUBLE_BLOCK_SIZE) : 1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(DOUBLE_BLOCK_SIZE - 1);

    agent_state_t            state_q,      state_d;
    cc_req_t                 type_q,       type_d;
    word_t                   addr_q,       addr_d;
    logic [LINE_W-1:0]       wdata_q,      wdata_d;
    logic [BEAT_CNT_W-1:0]   beat_q,       beat_d;
    logic [LINE_W-1:0]       line_q,       line_d;
    mesi_t                   resp_state_q, resp_state_d;
    logic                    lost_q,       lost_d;

    logic      snoop_hit;
    logic      snoop_dirty;
    longWord_t supply_data;
    longWord_t beat_word;
    logic      in_req;

    cc_snoop_resp u_snoop (
        .clk           (CLK),
        .rst           (RST),
        .ccwait        (bus.ccwait),
        .ccinv         (bus.ccinv),
        .ccsnoopaddr   (bus.ccsnoopaddr),
        .snp_state     (snp_state),
        .snp_data      (snp_data),
        .snp_addr      (snp_addr),
        .snp_inv       (snp_inv),
        .snp_to_shared (snp_to_shared),
        .snoop_hit     (snoop_hit),
        .snoop_dirty   (snoop_dirty),
        .supply_data   (supply_data)
    );

    // Request FSM next state, beat counter, fill capture and upgrade-loss tracking.
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        line_d       = line_q;
        resp_state_d = resp_state_q;
        lost_d       = lost_q;
        case (state_q)
            IDLE: begin
                // An invalidating snoop on the line we want to upgrade means we no
                // longer hold a copy, so the upgrade must become a full READX.
                if (!req_valid) begin
                    lost_d = 1'b0;
                end else if (req_type == CC_UPGRADE && bus.ccwait && bus.ccinv &&
                             same_line(bus.ccsnoopaddr, req_addr)) begin
                    lost_d = 1'b1;
                end
                if (req_valid && !bus.ccwait) begin
                    state_d = REQ;
                    type_d  = (req_type == CC_UPGRADE && lost_q) ? CC_READX : req_type;
                    addr_d  = line_base(req_addr);
                    wdata_d = req_wdata;
                    beat_d  = '0;
                    lost_d  = 1'b0;
                end
            end
            REQ: begin
                if (type_q == CC_UPGRADE) begin
                    if (!bus.ccwait && bus.ccexclusive) begin
                        state_d      = DONE;
                        resp_state_d = M;
                    end
                end else if (!bus.dwait) begin
                    if (type_q == CC_READ || type_q == CC_READX) begin
                        for (int k = 0; k < DOUBLE_BLOCK_SIZE; k++) begin
                            if (beat_q == BEAT_CNT_W'(k)) line_d[k*64 +: 64] = bus.dload;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        case (type_q)
                            CC_READ:  resp_state_d = bus.ccexclusive ? E : S;
                            CC_READX: resp_state_d = M;
                            default:  resp_state_d = I;
                        endcase
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus strobes and data mux; a writeback in flight keeps its own data on dstore
    // even if a snoop hits the same line.
    always_comb begin
        beat_word = '0;
        for (int k = 0; k < DOUBLE_BLOCK_SIZE; k++) begin
            if (beat_q == BEAT_CNT_W'(k)) beat_word = wdata_q[k*64 +: 64];
        end
        in_req          = (state_q == REQ);
        bus.dREN        = in_req && (type_q == CC_READ || type_q == CC_READX);
        bus.ccwrite     = in_req && (type_q == CC_READX);
        bus.cctrans     = in_req && (type_q == CC_UPGRADE);
        bus.dWEN        = in_req && (type_q == CC_WB);
        bus.daddr       = addr_q;
        bus.dstore      = (in_req && type_q == CC_WB) ? beat_word : supply_data;
        bus.ccsnoophit  = snoop_hit;
        bus.ccIsPresent = snoop_hit;
        bus.ccdirty     = snoop_dirty;
        req_done        = (state_q == DONE);
        resp_line       = line_q;
        resp_state      = resp_state_q;
        dbg_state       = state_q;
    end

    // Request-side state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            type_q       <= CC_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            resp_state_q <= I;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            resp_state_q <= resp_state_d;
            lost_q       <= lost_d;
        end
    end

endmodule

// File: tb/tb_cache_bus_agent.sv
// Bench for cache_bus_agent: directed requests and snoops, with expected
// completions and snoop pulses queued at issue and checked by a monitor.
module tb_cache_bus_agent;
    import cc_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    cc_req_t      req_type;
    word_t        req_addr;
    longWord_t    req_wdata;
    logic         req_done;
    longWord_t    resp_line;
    mesi_t        resp_state;
    word_t        snp_addr;
    mesi_t        snp_state;
    longWord_t    snp_data;
    logic         snp_inv;
    logic         snp_to_shared;
    agent_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // {check_line, state, line}
    logic [66:0] exp_q[$];
    // {inv, to_shared, addr}
    logic [33:0] snp_q[$];

    cache_bus_agent_if bus_if();

    cache_bus_agent #(.DOUBLE_BLOCK_SIZE(1)) dut (
        .CLK           (clk),
        .RST           (rst),
        .req_valid     (req_valid),
        .req_type      (req_type),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_done      (req_done),
        .resp_line     (resp_line),
        .resp_state    (resp_state),
        .snp_addr      (snp_addr),
        .snp_state     (snp_state),
        .snp_data      (snp_data),
        .snp_inv       (snp_inv),
        .snp_to_shared (snp_to_shared),
        .dbg_state     (dbg_state),
        .bus           (bus_if)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT signals a completion or snoop pulse.
    logic [66:0] e_req;
    logic [33:0] e_snp;
    always @(negedge clk) begin
        if (!rst) begin
            if (req_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req_done", 1'b1, 1'b0);
                end else begin
                    e_req = exp_q.pop_front();
                    check("resp_state", resp_state, e_req[65:64]);
                    if (e_req[66]) check("resp_line", resp_line, e_req[63:0]);
                end
            end
            if (snp_inv || snp_to_shared) begin
                if (snp_q.size() == 0) begin
                    check("unexpected_snoop_pulse", {snp_inv, snp_to_shared}, 2'b00);
                end else begin
                    e_snp = snp_q.pop_front();
                    check("snoop_pulse", {snp_inv, snp_to_shared}, e_snp[33:32]);
                    check("snoop_pulse_addr", snp_addr, e_snp[31:0]);
                end
            end
            check("one_strobe", 1'($countones({bus_if.dREN, bus_if.dWEN, bus_if.cctrans}) > 1), 1'b0);
        end
    end

    task automatic wait_req_state();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dbg_state != REQ && n < 20);
        check("enter_req", dbg_state, REQ);
    endtask

    task automatic run_req(input cc_req_t t, input word_t a, input longWord_t wd, input int stall,
                           input longWord_t ld, input logic ex, input mesi_t es, input logic chk_line);
        exp_q.push_back({chk_line, es, ld});
        @(posedge clk); #1;
        req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
        bus_if.dwait = 1'b1; bus_if.ccexclusive = 1'b0; bus_if.dload = '0;
        wait_req_state();
        for (int c = 0; c <= stall; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            check("dREN", bus_if.dREN, t == CC_READ || t == CC_READX);
            check("ccwrite", bus_if.ccwrite, t == CC_READX);
            check("cctrans", bus_if.cctrans, t == CC_UPGRADE);
            check("dWEN", bus_if.dWEN, t == CC_WB);
            check("daddr", bus_if.daddr, a & 32'hFFFF_FFF8);
            if (t == CC_WB) check("dstore_wb", bus_if.dstore, wd);
        end
        @(posedge clk); #1;
        bus_if.dwait = 1'b0; bus_if.dload = ld; bus_if.ccexclusive = ex;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_if.dwait = 1'b1; bus_if.ccexclusive = 1'b0;
        @(negedge clk);
        check("done_state", dbg_state, DONE);
        check("strobes_in_done", {bus_if.dREN, bus_if.dWEN, bus_if.cctrans, bus_if.ccwrite}, 4'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_snoop(input word_t a, input mesi_t st, input longWord_t d, input logic inv);
        logic hit;
        hit = (st != I);
        @(posedge clk); #1;
        bus_if.ccwait = 1'b1; bus_if.ccsnoopaddr = a; bus_if.ccinv = inv;
        snp_state = st; snp_data = d;
        if (hit) snp_q.push_back({inv, !inv, a});
        #1;
        check("ccsnoophit", bus_if.ccsnoophit, hit);
        check("ccIsPresent", bus_if.ccIsPresent, hit);
        check("snp_addr", snp_addr, a);
        @(posedge clk); #1;
        @(negedge clk);
        check("ccdirty", bus_if.ccdirty, st == M);
        if (hit) check("dstore_supply", bus_if.dstore, d);
        @(posedge clk); #1;
        bus_if.ccwait = 1'b0; bus_if.ccinv = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        snp_state = I;
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stimulus.
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_type = CC_READ; req_addr = '0; req_wdata = '0;
        snp_state = I; snp_data = '0;
        bus_if.dwait = 1'b1; bus_if.ccwait = 1'b0; bus_if.ccinv = 1'b0;
        bus_if.ccexclusive = 1'b0; bus_if.dload = '0; bus_if.ccsnoopaddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_strobes", {bus_if.dREN, bus_if.dWEN, bus_if.cctrans, bus_if.ccwrite}, 4'b0);
        check("rst_daddr", bus_if.daddr, 32'h0);
        check("rst_dstore", bus_if.dstore, 64'h0);
        check("rst_resp_line", resp_line, 64'h0);
        check("rst_resp_state", resp_state, I);
        check("rst_pulses", {req_done, snp_inv, snp_to_shared, bus_if.ccdirty}, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_req(CC_READ,    32'h0000_0040, 64'h0, 2, 64'hDEAD_BEEF_0123_4567, 1'b1, E, 1'b1);
        run_req(CC_READX,   32'h0000_1004, 64'h0, 1, 64'h1111_2222_3333_4444, 1'b0, M, 1'b1);
        run_req(CC_READ,    32'h0000_2A10, 64'h0, 0, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, S, 1'b1);
        run_req(CC_WB,      32'h0000_3008, 64'hCAFE_F00D_1234_5678, 1, 64'h0, 1'b0, I, 1'b0);
        run_req(CC_UPGRADE, 32'h0000_4000, 64'h0, 1, 64'h0, 1'b1, M, 1'b0);

        run_snoop(32'h0000_2000, M, 64'h0000_0000_0000_00A5, 1'b0);
        run_snoop(32'h0000_2100, S, 64'h0000_0000_0000_0077, 1'b1);
        run_snoop(32'h0000_2200, E, 64'h0000_0000_0000_0033, 1'b0);
        run_snoop(32'h0000_2300, I, 64'h0000_0000_0000_0099, 1'b1);

        // Upgrade held off by a snoop that invalidates the same line: must reissue as READX.
        exp_q.push_back({1'b1, M, 64'h0BAD_F00D_5555_AAAA});
        snp_q.push_back({1'b1, 1'b0, 32'h0000_5000});
        @(posedge clk); #1;
        bus_if.ccwait = 1'b1; bus_if.ccinv = 1'b1; bus_if.ccsnoopaddr = 32'h0000_5000; snp_state = S;
        req_valid = 1'b1; req_type = CC_UPGRADE; req_addr = 32'h0000_5000; bus_if.dwait = 1'b1;
        @(negedge clk);
        check("upg_blocked_cctrans", bus_if.cctrans, 1'b0);
        check("upg_blocked_hit", bus_if.ccsnoophit, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("upg_blocked_cctrans2", bus_if.cctrans, 1'b0);
        check("upg_blocked_state", dbg_state, IDLE);
        @(posedge clk); #1;
        bus_if.ccwait = 1'b0; bus_if.ccinv = 1'b0; snp_state = I;
        wait_req_state();
        check("lost_upg_dREN", bus_if.dREN, 1'b1);
        check("lost_upg_ccwrite", bus_if.ccwrite, 1'b1);
        check("lost_upg_cctrans", bus_if.cctrans, 1'b0);
        @(posedge clk); #1;
        bus_if.dwait = 1'b0; bus_if.dload = 64'h0BAD_F00D_5555_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_if.dwait = 1'b1;
        @(posedge clk); #1;

        // Writeback in flight while the controller snoops the same line.
        exp_q.push_back({1'b0, I, 64'h0});
        req_valid = 1'b1; req_type = CC_WB; req_addr = 32'h0000_6000;
        req_wdata = 64'hFEED_FACE_0000_6000; bus_if.dwait = 1'b1;
        wait_req_state();
        @(posedge clk); #1;
        bus_if.ccwait = 1'b1; bus_if.ccsnoopaddr = 32'h0000_6000;
        snp_state = M; snp_data = 64'h0000_0000_0000_5A5A;
        snp_q.push_back({1'b0, 1'b1, 32'h0000_6000});
        @(negedge clk);
        check("wb_snoop_hit", bus_if.ccsnoophit, 1'b1);
        check("wb_snoop_dWEN", bus_if.dWEN, 1'b1);
        check("wb_snoop_dstore", bus_if.dstore, 64'hFEED_FACE_0000_6000);
        @(posedge clk); #1;
        @(negedge clk);
        check("wb_snoop_dirty", bus_if.ccdirty, 1'b1);
        check("wb_snoop_dWEN2", bus_if.dWEN, 1'b1);
        check("wb_snoop_dstore2", bus_if.dstore, 64'hFEED_FACE_0000_6000);
        @(posedge clk); #1;
        bus_if.ccwait = 1'b0; bus_if.dwait = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_if.dwait = 1'b1; snp_state = I;
        @(negedge clk);
        check("wb_done_state", dbg_state, DONE);
        @(posedge clk); #1;

        // Reset in the middle of a READ: strobes drop, no completion, state back to I.
        req_valid = 1'b1; req_type = CC_READ; req_addr = 32'h0000_7000; bus_if.dwait = 1'b1;
        wait_req_state();
        check("pre_rst_dREN", bus_if.dREN, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_dREN", bus_if.dREN, 1'b0);
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_resp_state", resp_state, I);
        check("rst_mid_resp_line", resp_line, 64'h0);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("snp_q_drained", 32'(snp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
